// File: rtl/csr_pkg.sv
// Shared constants for the CSR access initiator: CSR numbers, funct3 codes, FSM states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE,
    S_T_EPC,
    S_T_CAUSE,
    S_T_VEC,
    S_T_DONE
  } state_t;

endpackage

// File: rtl/csr_rmw.sv
// Read-modify-write data path: merges the old CSR value with the operand.
// Only funct3[1:0] matters here; the immediate/register choice is already
// folded into the operand.
module csr_rmw
  import csr_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] old_q,
  input  logic [31:0] operand,
  output logic [31:0] wdata
);

  // Write data selection by operation kind
  always_comb begin
    wdata = operand;
    if (op == F3_RS[1:0])
      wdata = old_q | operand;
    else if (op == F3_RC[1:0])
      wdata = old_q & ~operand;
  end

endmodule

// File: rtl/csr_master.sv
// CSR access initiator: sequences read/modify/write and trap-entry accesses
// on the single-port CSR register-file bus.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | ready; accepts a trap (priority) or a CSR instruction
// S_RD      | bus read of the CSR, old value captured at cycle end
// S_WR      | bus write of the merged value
// S_DONE    | done_o pulse, or illegal_o pulse for a rejected request
// S_T_EPC   | write faulting PC to mepc
// S_T_CAUSE | write cause to mcause
// S_T_VEC   | read mtvec in exception mode
// S_T_DONE  | redirect_valid_o pulse with the trap vector
module csr_master
  import csr_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              trap_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        op_i,
  input  logic [11:0]       csr_num_i,
  input  logic [31:0]       rs1_data_i,
  input  logic [4:0]        zimm_i,
  input  logic              rd_nz_i,
  input  logic              rs1_nz_i,
  input  logic [31:0]       trap_pc_i,
  input  logic [31:0]       trap_cause_i,
  output logic [ADDR_W-1:0] csr_address_o,
  output logic              csr_en_read_o,
  output logic              csr_en_write_o,
  output logic [31:0]       csr_data_o,
  output logic              csr_en_except_o,
  input  logic [31:0]       csr_data_i,
  output logic              done_o,
  output logic [31:0]       rd_data_o,
  output logic              illegal_o,
  output logic              redirect_valid_o,
  output logic [31:0]       redirect_pc_o
);

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [11:0] num_q;
  logic [31:0] operand_q, old_q, rd_q, pc_q, cause_q, wdata;
  logic        do_write_q, illegal_q;

  logic [31:0] operand_in;
  logic        is_rw_in, do_read_in, do_write_in, illegal_in;

  // Decode of the incoming instruction, used only at acceptance
  always_comb begin
    operand_in  = op_i[2] ? {27'b0, zimm_i} : rs1_data_i;
    is_rw_in    = (op_i[1:0] == F3_RW[1:0]);
    do_read_in  = !(is_rw_in && !rd_nz_i);
    do_write_in = is_rw_in || (op_i[2] ? (zimm_i != 5'd0) : rs1_nz_i);
    illegal_in  = (op_i[1:0] == 2'b00) || (do_write_in && csr_num_i[11:10] == 2'b11);
  end

  csr_rmw u_rmw (
    .op      (op_q),
    .old_q   (old_q),
    .operand (operand_q),
    .wdata   (wdata)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trap_valid_i)     state_d = S_T_EPC;
        else if (req_valid_i) state_d = illegal_in ? S_DONE : (do_read_in ? S_RD : S_WR);
      end
      S_RD:      state_d = do_write_q ? S_WR : S_DONE;
      S_WR:      state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_T_EPC:   state_d = S_T_CAUSE;
      S_T_CAUSE: state_d = S_T_VEC;
      S_T_VEC:   state_d = S_T_DONE;
      S_T_DONE:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Request latching, old-value capture and writeback value.
  // old_q is cleared on instruction acceptance so write-only ops return 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q       <= 2'b00;
      num_q      <= 12'h000;
      operand_q  <= 32'h0;
      do_write_q <= 1'b0;
      illegal_q  <= 1'b0;
      pc_q       <= 32'h0;
      cause_q    <= 32'h0;
      old_q      <= 32'h0;
      rd_q       <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trap_valid_i) begin
            pc_q    <= trap_pc_i;
            cause_q <= trap_cause_i;
          end else if (req_valid_i) begin
            op_q       <= op_i[1:0];
            num_q      <= csr_num_i;
            operand_q  <= operand_in;
            do_write_q <= do_write_in;
            illegal_q  <= illegal_in;
            old_q      <= 32'h0;
          end
        end
        S_RD: begin
          old_q <= csr_data_i;
          if (!do_write_q) rd_q <= csr_data_i;
        end
        S_WR:    rd_q  <= old_q;
        S_T_VEC: old_q <= csr_data_i;
        default: ;
      endcase
    end
  end

  // Bus and handshake outputs decoded from the registered state
  always_comb begin
    req_ready_o      = (state_q == S_IDLE);
    csr_address_o    = '0;
    csr_en_read_o    = 1'b0;
    csr_en_write_o   = 1'b0;
    csr_data_o       = 32'h0;
    csr_en_except_o  = 1'b0;
    done_o           = 1'b0;
    illegal_o        = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'h0;
    case (state_q)
      S_RD: begin
        csr_address_o = ADDR_W'(num_q);
        csr_en_read_o = 1'b1;
      end
      S_WR: begin
        csr_address_o  = ADDR_W'(num_q);
        csr_en_write_o = 1'b1;
        csr_data_o     = wdata;
      end
      S_DONE: begin
        done_o    = !illegal_q;
        illegal_o = illegal_q;
      end
      S_T_EPC: begin
        csr_address_o  = ADDR_W'(CSR_MEPC);
        csr_en_write_o = 1'b1;
        csr_data_o     = pc_q;
      end
      S_T_CAUSE: begin
        csr_address_o  = ADDR_W'(CSR_MCAUSE);
        csr_en_write_o = 1'b1;
        csr_data_o     = cause_q;
      end
      S_T_VEC: begin
        csr_address_o   = ADDR_W'(CSR_MTVEC);
        csr_en_read_o   = 1'b1;
        csr_en_except_o = 1'b1;
      end
      S_T_DONE: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = {old_q[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  assign rd_data_o = rd_q;

endmodule

// File: tb/tb_csr_master.sv
// Scoreboard bench for csr_master with a behavioural CSR register file.
module tb_csr_master;
  import csr_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0, trap_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  op_i = 3'b000;
  logic [11:0] csr_num_i = 12'h0;
  logic [31:0] rs1_data_i = 32'h0;
  logic [4:0]  zimm_i = 5'h0;
  logic        rd_nz_i = 1'b0, rs1_nz_i = 1'b0;
  logic [31:0] trap_pc_i = 32'h0, trap_cause_i = 32'h0;
  logic [31:0] csr_address_o;
  logic        csr_en_read_o, csr_en_write_o, csr_en_except_o;
  logic [31:0] csr_data_o;
  logic [31:0] csr_data_i = 32'h0;
  logic        done_o, illegal_o, redirect_valid_o;
  logic [31:0] rd_data_o, redirect_pc_o;

  always #5 clk_i = ~clk_i;

  csr_master #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .trap_valid_i(trap_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .csr_num_i(csr_num_i), .rs1_data_i(rs1_data_i), .zimm_i(zimm_i),
    .rd_nz_i(rd_nz_i), .rs1_nz_i(rs1_nz_i), .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
    .csr_address_o(csr_address_o), .csr_en_read_o(csr_en_read_o), .csr_en_write_o(csr_en_write_o),
    .csr_data_o(csr_data_o), .csr_en_except_o(csr_en_except_o), .csr_data_i(csr_data_i),
    .done_o(done_o), .rd_data_o(rd_data_o), .illegal_o(illegal_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  // Register file model: acts on the falling edge after the strobe
  logic [31:0] mem [0:4095];
  always @(negedge clk_i) begin
    if (csr_en_write_o) mem[csr_address_o[11:0]] = csr_data_o;
    if (csr_en_read_o)  csr_data_i = mem[csr_address_o[11:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  localparam int K_DONE = 0, K_ILL = 1, K_REDIR = 2;
  typedef struct { int kind; logic [31:0] data; } exp_t;
  exp_t sb[$];

  // Monitor: pops the scoreboard whenever the DUT reports a completion
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (csr_en_read_o || csr_en_write_o)
        chk("bus_exclusive", {31'b0, csr_en_read_o & csr_en_write_o}, 32'h0);
      if (done_o || illegal_o || redirect_valid_o) begin
        int k;
        logic [31:0] d;
        k = done_o ? K_DONE : (illegal_o ? K_ILL : K_REDIR);
        d = done_o ? rd_data_o : (redirect_valid_o ? redirect_pc_o : 32'h0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response actual_kind=%0d required=none", k);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_kind", 32'(k), 32'(e.kind));
          chk("resp_data", d, e.data);
        end
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [11:0] num,
                        input logic [31:0] rs1, input logic [4:0] zimm, input logic rd_nz,
                        input logic rs1_nz, input int kind, input logic [31:0] data,
                        input int exp_lat, input int exp_rd, input int exp_wr);
    int lat, nrd, nwr;
    lat = -1; nrd = 0; nwr = 0;
    @(negedge clk_i);
    op_i = op; csr_num_i = num; rs1_data_i = rs1; zimm_i = zimm;
    rd_nz_i = rd_nz; rs1_nz_i = rs1_nz; req_valid_i = 1'b1;
    sb.push_back('{kind, data});
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk_i);
      nrd += int'(csr_en_read_o);
      nwr += int'(csr_en_write_o);
      if (done_o || illegal_o) begin
        lat = n;
        break;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_reads"}, 32'(nrd), 32'(exp_rd));
    chk({name, "_writes"}, 32'(nwr), 32'(exp_wr));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h305] = 32'h0000_1234;
    mem[12'h304] = 32'h0000_5555;
    mem[12'h300] = 32'h0000_0088;
    mem[12'hF11] = 32'h0000_0ABC;

    #12;
    chk("rst_ready", {31'b0, req_ready_o}, 32'h1);
    chk("rst_strobes", {29'b0, csr_en_read_o, csr_en_write_o, csr_en_except_o}, 32'h0);
    chk("rst_pulses", {29'b0, done_o, illegal_o, redirect_valid_o}, 32'h0);
    chk("rst_rd_data", rd_data_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    run_op("csrrw_mtvec", F3_RW, 12'h305, 32'h8000_0100, 5'd0, 1'b1, 1'b1, K_DONE, 32'h0000_1234, 3, 1, 1);
    chk("mtvec_written", mem[12'h305], 32'h8000_0100);
    run_op("readback_mtvec", F3_RS, 12'h305, 32'h0, 5'd0, 1'b1, 1'b0, K_DONE, 32'h8000_0100, 2, 1, 0);
    run_op("csrrs_ro", F3_RS, 12'h304, 32'h0000_FFFF, 5'd0, 1'b1, 1'b0, K_DONE, 32'h0000_5555, 2, 1, 0);
    run_op("csrrci", F3_RCI, 12'h300, 32'hFFFF_FFFF, 5'h08, 1'b1, 1'b0, K_DONE, 32'h0000_0088, 3, 1, 1);
    chk("mstatus_cleared", mem[12'h300], 32'h0000_0080);
    run_op("csrrs_set", F3_RS, 12'h304, 32'h0000_000F, 5'd0, 1'b1, 1'b1, K_DONE, 32'h0000_5555, 3, 1, 1);
    chk("mie_set", mem[12'h304], 32'h0000_555F);
    run_op("csrrw_wo", F3_RW, 12'h340, 32'h0000_DEAD, 5'd0, 1'b0, 1'b1, K_DONE, 32'h0, 2, 0, 1);
    chk("mscratch_written", mem[12'h340], 32'h0000_DEAD);
    run_op("ill_ro_write", F3_RW, 12'hF11, 32'h1, 5'd0, 1'b1, 1'b1, K_ILL, 32'h0, 1, 0, 0);
    chk("ro_untouched", mem[12'hF11], 32'h0000_0ABC);
    run_op("ill_op100", 3'b100, 12'h300, 32'h1, 5'd1, 1'b1, 1'b1, K_ILL, 32'h0, 1, 0, 0);
    run_op("ro_read_ok", F3_RS, 12'hF11, 32'h1, 5'd0, 1'b1, 1'b0, K_DONE, 32'h0000_0ABC, 2, 1, 0);
    run_op("rsi_zero", F3_RSI, 12'hF12, 32'h0, 5'd0, 1'b1, 1'b1, K_DONE, 32'h0, 2, 1, 0);

    begin : trap_test
      int lat, nexc, bad_exc, nrd, nwr;
      logic seen_done;
      lat = -1; nexc = 0; bad_exc = 0; nrd = 0; nwr = 0; seen_done = 1'b0;
      @(negedge clk_i);
      mem[12'h305] = 32'h0000_0203;
      trap_pc_i = 32'h40; trap_cause_i = 32'h2; trap_valid_i = 1'b1;
      op_i = F3_RW; csr_num_i = 12'h340; rs1_data_i = 32'h5A5A; rd_nz_i = 1'b1; rs1_nz_i = 1'b1;
      req_valid_i = 1'b1;
      sb.push_back('{K_REDIR, 32'h0000_0200});
      @(posedge clk_i);
      #1 trap_valid_i = 1'b0; req_valid_i = 1'b0;
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk_i);
        nrd += int'(csr_en_read_o);
        nwr += int'(csr_en_write_o);
        nexc += int'(csr_en_except_o);
        if (csr_en_except_o && !csr_en_read_o) bad_exc++;
        if (done_o) seen_done = 1'b1;
        if (redirect_valid_o) begin
          lat = n;
          break;
        end
      end
      chk("trap_latency", 32'(lat), 32'd4);
      chk("trap_mepc", mem[12'h341], 32'h40);
      chk("trap_mcause", mem[12'h342], 32'h2);
      chk("trap_except_cycles", 32'(nexc), 32'd1);
      chk("trap_except_on_read", 32'(bad_exc), 32'd0);
      chk("trap_bus_counts", 32'(nrd * 16 + nwr), 32'h12);
      chk("trap_req_ignored", {31'b0, seen_done}, 32'h0);
      chk("trap_mscratch_kept", mem[12'h340], 32'h0000_DEAD);
    end

    begin : reset_test
      logic seen_done;
      seen_done = 1'b0;
      @(negedge clk_i);
      op_i = F3_RW; csr_num_i = 12'h340; rs1_data_i = 32'h1111; rd_nz_i = 1'b1; rs1_nz_i = 1'b1;
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      @(posedge clk_i);
      #1 chk("pre_rst_in_wr", {31'b0, csr_en_write_o}, 32'h1);
      #1 rst_i = 1'b0;
      #1;
      chk("rst_write_drop", {30'b0, csr_en_write_o, csr_en_read_o}, 32'h0);
      chk("rst_idle", {31'b0, req_ready_o}, 32'h1);
      chk("rst_rd_cleared", rd_data_o, 32'h0);
      for (int n = 0; n < 3; n++) begin
        @(negedge clk_i);
        if (done_o) seen_done = 1'b1;
      end
      chk("rst_no_done", {31'b0, seen_done}, 32'h0);
      chk("rst_no_partial_write", mem[12'h340], 32'h0000_DEAD);
      rst_i = 1'b1;
    end

    run_op("post_rst_read", F3_RS, 12'h340, 32'h0, 5'd0, 1'b1, 1'b0, K_DONE, 32'h0000_DEAD, 2, 1, 0);

    repeat (3) @(negedge clk_i);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_master.md
# csr_master

CSR access initiator for the machine-mode CSR register file. It accepts one decoded CSR instruction or one trap-entry request at a time, and sequences the read, modify and write accesses on the register file's single-port bus. It returns the old CSR value to the writeback stage, or a trap-vector redirect to fetch. It sits between decode/execute and the CSR register file, and is the only agent driving that bus.

## Interface
Parameters:
- ADDR_W, 32: width of the CSR bus address; the 12-bit CSR number is zero-extended to this width.

Ports (reset is asynchronous, active-low, on `rst_i`; single clock `clk_i`, rising edge):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  CSR instruction request
- trap_valid_i  in  1  trap-entry request
- req_ready_o  out  1  high only in IDLE; accepts either request
- op_i  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- csr_num_i  in  12  CSR number
- rs1_data_i  in  32  register operand
- zimm_i  in  5  immediate operand (xxI ops)
- rd_nz_i  in  1  rd != x0
- rs1_nz_i  in  1  rs1 != x0
- trap_pc_i  in  32  faulting PC, written to mepc
- trap_cause_i  in  32  written to mcause
- csr_address_o  out  ADDR_W  bus address
- csr_en_read_o  out  1  bus read strobe
- csr_en_write_o  out  1  bus write strobe
- csr_data_o  out  32  bus write data
- csr_en_except_o  out  1  bus exception-mode flag
- csr_data_i  in  32  bus read data
- done_o  out  1  one-cycle pulse; instruction finished
- rd_data_o  out  32  old CSR value, valid with done_o
- illegal_o  out  1  one-cycle pulse; instruction rejected
- redirect_valid_o  out  1  one-cycle pulse; trap entry done
- redirect_pc_o  out  32  trap target, valid with redirect_valid_o

## Operation
- FSM states: IDLE, RD, WR, DONE, T_EPC, T_CAUSE, T_VEC, T_DONE.
- Request acceptance:
  - Requests are accepted in IDLE only.
  - trap_valid_i wins over req_valid_i when both are high; the losing request is ignored and the requester must hold it.
- Request latching: inputs are latched at acceptance.
- Operand selection: operand = zimm_i zero-extended for ops 1xx, otherwise rs1_data_i.
- Access decisions:
  - do_read = !(op is RW/RWI && !rd_nz_i).
  - do_write = op is RW/RWI, or operand source nonzero (rs1_nz_i, or zimm_i != 0).
- Illegal cases, each producing one illegal_o pulse and a return to IDLE with no bus activity:
  - op 000 or 100;
  - do_write with csr_num[11:10] == 2'b11 (read-only CSR).
- Instruction path:
  - IDLE → RD if do_read, else WR.
  - RD → WR if do_write, else DONE.
  - WR → DONE.
  - DONE → IDLE.
- RD: csr_en_read_o=1; old_q <= csr_data_i at the end of the cycle.
- WR: csr_en_write_o=1; csr_data_o per op:
  - RW: operand;
  - RS: old_q | operand;
  - RC: old_q & ~operand.
- Trap path, all with csr_en_except_o=0 unless noted:
  - T_EPC: write 0x341 with trap_pc_i.
  - T_CAUSE: write 0x342 with trap_cause_i.
  - T_VEC: read 0x305 with csr_en_except_o=1.
  - T_DONE: redirect_pc_o = {mtvec[31:2], 2'b00} (direct mode only).
- Bus exclusivity: csr_en_read_o and csr_en_write_o are never high together.
- Idle bus outputs: outside RD/WR/T_* states, all bus outputs are 0.

## Timing
- Reset values: FSM = IDLE; all outputs 0 except req_ready_o=1; old_q = 0.
- Assertion of rst_i mid-sequence aborts immediately, with no partial-write completion.
- Bus outputs are registered and change on the rising edge. The register file acts on the following falling edge, so read data is sampled on the next rising edge (1-cycle read).
- Latency from the acceptance edge to the done_o cycle:
  - read+write: 3 cycles;
  - read-only or write-only: 2 cycles;
  - illegal: illegal_o in cycle 1.
- Trap latency: redirect_valid_o in cycle 4.
- req_ready_o is low from the cycle after acceptance until the cycle after done_o, illegal_o or redirect_valid_o.
- rd_data_o holds its value until the next done_o; it is 0 for write-only ops.

## Structure
- Package csr_pkg holds:
  - the 12-bit CSR number constants (0x300–0x344, 0xB00–0xB82, 0xF11–0xF14);
  - funct3 constants;
  - the FSM state enum.
- Sub-module csr_rmw (combinational): inputs op, old_q and operand; outputs write data.

## Test plan
- CSRRW 0x305, rs1=0x8000_0100, rd_nz=1, mtvec preloaded 0x1234 → RD then WR on the bus; rd_data_o=0x1234 with done_o at cycle 3; a readback gives 0x8000_0100.
- CSRRS 0x304, rs1_nz=0 → read only, no csr_en_write_o; done_o at cycle 2.
- CSRRCI 0x300, zimm=0x08, mstatus=0x88 → write data 0x80; rd_data_o=0x88.
- CSRRW 0xF11, or op=100 → illegal_o at cycle 1; no bus strobes.
- trap_valid_i and req_valid_i together, pc=0x40, cause=0x2, mtvec=0x203 → writes mepc=0x40 and mcause=0x2; csr_en_except_o=1 on the mtvec read; redirect_pc_o=0x200 at cycle 4; the CSR request is not accepted.
- rst_i low during WR → strobes drop asynchronously, the FSM is in IDLE, and no done_o is issued.
